// File: rtl/regfile_wport_ctrl_if.sv
// Write-port bundle for regfile_wport_ctrl.
// Holds the core, host, clear-engine and register-file sides.
interface regfile_wport_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          core_we;
  logic [AW-1:0] core_wa;
  logic [DW-1:0] core_wd;
  logic          core_stall;
  logic          host_req;
  logic [AW-1:0] host_wa;
  logic [DW-1:0] host_wd;
  logic          host_ack;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  modport master (
    input  core_we,
    input  core_wa,
    input  core_wd,
    output core_stall,
    input  host_req,
    input  host_wa,
    input  host_wd,
    output host_ack,
    input  clr_start,
    output clr_busy,
    output clr_done,
    output rf_we,
    output rf_wa,
    output rf_wd
  );

  modport slave (
    output core_we,
    output core_wa,
    output core_wd,
    input  core_stall,
    output host_req,
    output host_wa,
    output host_wd,
    input  host_ack,
    output clr_start,
    input  clr_busy,
    input  clr_done,
    input  rf_we,
    input  rf_wa,
    input  rf_wd
  );
endinterface

// File: rtl/regfile_wport_ctrl.sv
// Write-port arbiter for the 32x32 register file:
// core writeback, host req/ack writes and a sequential clear engine.
module regfile_wport_ctrl #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int CLR_LO     = 2,
  parameter int CLR_HI     = 25,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_wport_ctrl_if.master   bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic [SW-1:0] starve_cnt;
  logic          host_ack;
  logic          clr_done;

  logic          in_clr;
  logic          arb;
  logic          host_pend;
  logic          forced;
  logic          host_win;
  logic          core_win;

  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  // A request is not re-granted in its own ack cycle.
  always_comb begin
    in_clr    = (state == CLEAR);
    arb       = !in_clr;
    host_pend = bus.host_req & ~host_ack;
    forced    = arb & host_pend
              & (starve_cnt == SW'(STARVE_MAX));
    host_win  = arb & host_pend
              & (forced | ~bus.core_we);
    core_win  = arb & bus.core_we & ~forced;
  end

  // r0 is hardwired zero: grant proceeds, write is dropped.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    unique case (1'b1)
      in_clr: begin
        rf_we = 1'b1;
        rf_wa = clr_ptr;
      end
      host_win: begin
        rf_we = (bus.host_wa != '0);
        rf_wa = bus.host_wa;
        rf_wd = bus.host_wd;
      end
      core_win: begin
        rf_we = (bus.core_wa != '0);
        rf_wa = bus.core_wa;
        rf_wd = bus.core_wd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      clr_ptr    <= AW'(CLR_LO);
      starve_cnt <= '0;
      host_ack   <= 1'b0;
      clr_done   <= 1'b0;
    end else begin
      host_ack <= host_win;
      clr_done <= 1'b0;

      if (host_win)
        starve_cnt <= '0;
      else if (arb && host_pend &&
               starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.clr_start)
            state <= CLEAR;
        end
        CLEAR: begin
          if (clr_ptr == AW'(CLR_HI)) begin
            state    <= DONE;
            clr_done <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        DONE: begin
          clr_ptr <= AW'(CLR_LO);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.core_stall = in_clr | forced;
  assign bus.host_ack   = host_ack;
  assign bus.clr_busy   = in_clr;
  assign bus.clr_done   = clr_done;
  assign bus.rf_we      = rf_we;
  assign bus.rf_wa      = rf_wa;
  assign bus.rf_wd      = rf_wd;

endmodule

// File: tb/tb_regfile_wport_ctrl.sv
// Scoreboard bench for regfile_wport_ctrl.
// Stimulus pushes per-cycle expectations; a monitor pops and compares.
module tb_regfile_wport_ctrl;

  logic clk;
  logic reset;
  int   cyc;
  int   applied;
  int   miscompares;

  regfile_wport_ctrl_if #(.AW(5), .DW(32)) bus ();

  regfile_wport_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stall;
    logic        ack;
    logic        busy;
    logic        done;
    logic        dc;
  } exp_t;

  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      applied++;
      miscompares++;
      $display("FAIL missed vec@%0d: not observed", q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      logic bad;
      e = q.pop_front();
      applied++;
      bad = (bus.rf_we !== e.we) ||
            (bus.core_stall !== e.stall) ||
            (bus.host_ack !== e.ack) ||
            (bus.clr_busy !== e.busy) ||
            (bus.clr_done !== e.done) ||
            (!e.dc && (bus.rf_wa !== e.wa ||
                       bus.rf_wd !== e.wd));
      if (bad) begin
        miscompares++;
        $display("FAIL vec@%0d we/wa/wd/stall/ack/busy/done got %b/%0d/%h/%b/%b/%b/%b want %b/%0d/%h/%b/%b/%b/%b",
                 e.cyc, bus.rf_we, bus.rf_wa, bus.rf_wd,
                 bus.core_stall, bus.host_ack,
                 bus.clr_busy, bus.clr_done,
                 e.we, e.wa, e.wd, e.stall, e.ack,
                 e.busy, e.done);
      end
    end
  end

  task automatic drive(input logic cw,
                       input logic [4:0] cwa,
                       input logic [31:0] cwd,
                       input logic hr,
                       input logic [4:0] hwa,
                       input logic [31:0] hwd,
                       input logic cs);
    bus.core_we   = cw;
    bus.core_wa   = cwa;
    bus.core_wd   = cwd;
    bus.host_req  = hr;
    bus.host_wa   = hwa;
    bus.host_wd   = hwd;
    bus.clr_start = cs;
  endtask

  task automatic expect_cyc(input logic we,
                            input logic [4:0] wa,
                            input logic [31:0] wd,
                            input logic stall,
                            input logic ack,
                            input logic busy,
                            input logic done,
                            input logic dc);
    exp_t e;
    e.cyc   = cyc;
    e.we    = we;
    e.wa    = wa;
    e.wd    = wd;
    e.stall = stall;
    e.ack   = ack;
    e.busy  = busy;
    e.done  = done;
    e.dc    = dc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    expect_cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_run(input int first,
                           input int n,
                           input logic ack0);
    for (int i = 0; i < n; i++)
      expect_cyc(1, 5'(2 + first + i), 0, 1,
                 (i == 0) && ack0, 1, 0, 0);
  endtask

  initial begin
    cyc         = 0;
    applied     = 0;
    miscompares = 0;
    reset       = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    idle_exp();
    reset = 1'b1;
    idle_exp();

    // full clear sequence
    drive(0, 0, 0, 0, 0, 0, 1);
    idle_exp();
    drive(0, 0, 0, 0, 0, 0, 0);
    clear_run(0, 24, 0);
    expect_cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle_exp();

    // core write r9
    drive(1, 9, 32'hDEADBEEF, 0, 0, 0, 0);
    expect_cyc(1, 9, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    idle_exp();

    // host write r5, req held through ack
    drive(0, 0, 0, 1, 5, 32'h1234, 0);
    expect_cyc(1, 5, 32'h1234, 0, 0, 0, 0, 0);
    expect_cyc(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    idle_exp();

    // starvation: core busy, host r7 forced on 5th cycle
    drive(1, 3, 32'hA, 1, 7, 32'h77, 0);
    for (int i = 0; i < 4; i++)
      expect_cyc(1, 3, 32'hA, 0, 0, 0, 0, 0);
    expect_cyc(1, 7, 32'h77, 1, 0, 0, 0, 0);
    expect_cyc(1, 3, 32'hA, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    idle_exp();

    // reset while clr_ptr == 10
    drive(0, 0, 0, 0, 0, 0, 1);
    idle_exp();
    drive(0, 0, 0, 0, 0, 0, 0);
    clear_run(0, 8, 0);
    reset = 1'b0;
    expect_cyc(1, 10, 0, 1, 0, 1, 0, 0);
    reset = 1'b1;
    idle_exp();
    idle_exp();
    drive(0, 0, 0, 0, 0, 0, 1);
    idle_exp();
    drive(0, 0, 0, 0, 0, 0, 0);
    clear_run(0, 24, 0);
    expect_cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle_exp();

    // r0 writes are dropped, host still acked
    drive(1, 0, 32'h55, 0, 0, 0, 0);
    expect_cyc(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 32'h66, 0);
    expect_cyc(0, 0, 0, 0, 0, 0, 0, 1);
    expect_cyc(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    idle_exp();

    // clr_start with core write: core wins now, clear next
    drive(1, 4, 32'h44, 0, 0, 0, 1);
    expect_cyc(1, 4, 32'h44, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    clear_run(0, 24, 0);
    expect_cyc(0, 0, 0, 0, 0, 0, 1, 0);

    // clr_start with host grant: ack in first clear cycle
    drive(0, 0, 0, 1, 6, 32'h66, 1);
    expect_cyc(1, 6, 32'h66, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    clear_run(0, 24, 1);
    expect_cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle_exp();

    @(posedge clk);
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL leftover: %0d unchecked, want 0", q.size());
      miscompares += q.size();
      applied     += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
